gate_table_sweeper: RTL and testbench
=====================================

# gate_table_sweeper

Parametrised, clocked truth-table sweeper for the gate-characterisation drills. It walks every input combination of a selected primitive gate over 2-state {0,1} or 4-state {0,1,x,z} symbols and evaluates the gate with Verilog primitive semantics. Each row is emitted as one record over a valid/ready handshake. It sits between the drill benches and the log/display sink, and replaces hand-written per-gate stimulus sequences.

## Interface
- `N_IN`, 2, number of gate inputs (legal 2..4).
- `FOUR_STATE`, 1, symbol set: 1 = {0,1,x,z}, 0 = {0,1}.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `op`  in  2  gate select, latched on accepted start: 00 BUF, 01 NAND, 10 XNOR, 11 NOR.
- `busy`  out  1  high in EMIT and DONE.
- `rec_valid`  out  1  record on `rec_*` is valid.
- `rec_ready`  in  1  sink accepts record.
- `rec_idx`  out  2*N_IN  row sequence number, 0..count-1.
- `rec_in`  out  2*N_IN  encoded input symbols; input 0 (a) in the MSB pair, input N_IN-1 in bits [1:0].
- `rec_out`  out  2  encoded gate output.
- `done`  out  1  one-cycle pulse after the final record is accepted.

## Operation
- Symbol encoding (2 bits): 00 = 0, 01 = 1, 10 = x, 11 = z.
- SYMS = 4 if FOUR_STATE, else 2. Row count:
  - BUF: SYMS.
  - NAND, XNOR, NOR: SYMS^N_IN.
- Row ordering: base-SYMS counter, input 0 is the most significant digit, symbol order 0,1,x,z.
  - Four-state, multi-input: `rec_in` == `rec_idx`.
  - Two-state: each digit maps to symbol 00/01.
- BUF: only input 0 is swept; the other inputs are driven as symbol 0.
- Evaluation, with z at any input treated as x:
  - BUF: 0→0, 1→1, x/z→x.
  - NAND: any 0 → 1; all 1 → 0; else x.
  - NOR: any 1 → 0; all 0 → 1; else x.
  - XNOR: any x/z → x; else 1 if an even number of inputs are 1, 0 otherwise.
- `rec_out` is never z (11).
- FSM:
  - IDLE → EMIT on `start`: latch `op`, clear index.
  - EMIT: `rec_valid` = 1. On `rec_valid & rec_ready`: if index == count-1 go to DONE, else increment index.
  - DONE: `done` = 1, `rec_valid` = 0; go to IDLE next edge.
- `start` is ignored in EMIT and DONE. `op` changes mid-sweep are ignored.
- All `rec_*`, `busy` and `done` are functions of registered state only; no combinational input-to-output path.

## Timing
- Reset (`rst_n` = 0 at an edge), regardless of state:
  - FSM goes to IDLE.
  - `busy`, `rec_valid`, `done`, `rec_idx`, `rec_in`, `rec_out` are all 0.
  - Latched op is 00.
- Reset mid-sweep aborts the sweep with no `done` pulse and no further records.
- Start latency: `start` sampled at edge k → `rec_valid` = 1 and record 0 present after edge k.
- Throughput: one record per cycle while `rec_ready` is held high. Full sweep with `rec_ready` constant 1 occupies count EMIT cycles plus 1 DONE cycle.
- Backpressure: while `rec_valid` & !`rec_ready`, all `rec_*` are held stable. `rec_valid` never drops before acceptance.
- Final handshake at edge m → `done` = 1 for exactly the cycle after edge m, `busy` still 1 → IDLE after edge m+1.
- `start` asserted on the same edge that DONE exits to IDLE is not accepted. It must be sampled in IDLE.
- `rec_ready` is ignored outside EMIT.

## Test plan
- Reset: hold `rst_n` = 0 for 2 edges with `start` = 1 → all outputs 0; no record is emitted until `rst_n` = 1 and `start` is sampled in IDLE.
- NAND sweep (N_IN = 2, FOUR_STATE = 1, `rec_ready` = 1) → 16 records on consecutive cycles, then `done` 1 cycle. Required rows:
  - idx 0: in 0000, out 01.
  - idx 2: in 0010, out 01.
  - idx 5: in 0101, out 00.
  - idx 6: in 0110, out 10.
  - idx 15: in 1111, out 10.
- XNOR and BUF (N_IN = 2, FOUR_STATE = 1):
  - XNOR idx 1 → out 00; idx 5 → out 01; idx 7 → out 10.
  - BUF → exactly 4 records, `rec_in` 0000/0100/1000/1100, out 01? no: out 00, 01, 10, 10 in that order.
- Two-state NOR (N_IN = 3, FOUR_STATE = 0) → 8 records. idx 0 in 000000 out 01; idx 1..7 out 00. idx 7 has `rec_in` 010101.
- Backpressure: NAND sweep, `rec_ready` = 0 for 5 cycles while at idx 6 → `rec_idx` 6, `rec_in` 0110, `rec_out` 10 held stable; idx 7 appears the cycle after `rec_ready` returns to 1.
- Reset mid-sweep: pull `rst_n` low at idx 9 → next cycle all outputs 0, no `done`. A new `start` with `op` = 10 restarts at idx 0.

Source files
------------

// File: rtl/gate_table_sweeper_if.sv
// Record stream from the truth-table sweeper to its log/display sink.
interface gate_table_sweeper_if #(
  parameter int N_IN = 2
) ();
  logic              rec_valid;
  logic              rec_ready;
  logic [2*N_IN-1:0] rec_idx;
  logic [2*N_IN-1:0] rec_in;
  logic [1:0]        rec_out;

  modport master (output rec_valid, rec_idx, rec_in, rec_out, input rec_ready);
  modport slave  (input rec_valid, rec_idx, rec_in, rec_out, output rec_ready);
endinterface

// File: rtl/gate_table_sweeper.sv
// gate_table_sweeper: walks every input row of a primitive gate (BUF/NAND/XNOR/NOR)
// over {0,1} or {0,1,x,z} and emits one record per row on a valid/ready stream.
// Symbol encoding: 00=0, 01=1, 10=x, 11=z.

// Per-input symbol classifier; z is folded into x for gate evaluation.
module gts_lane (
  input  logic [1:0] sym,
  output logic       is0,
  output logic       is1,
  output logic       isx
);
  // classify one input symbol
  always_comb begin
    is0 = (sym == 2'b00);
    is1 = (sym == 2'b01);
    isx = sym[1];
  end
endmodule

module gate_table_sweeper #(
  parameter int N_IN       = 2,
  parameter bit FOUR_STATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  output logic                 busy,
  output logic                 done,
  gate_table_sweeper_if.master rec
);
  localparam int IW   = 2 * N_IN;
  localparam int SYMS = FOUR_STATE ? 4 : 2;
  localparam logic [IW-1:0] LAST_ALL = IW'(SYMS ** N_IN - 1);
  localparam logic [IW-1:0] LAST_BUF = IW'(SYMS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_e;
  typedef enum logic [1:0] {OP_BUF = 2'b00, OP_NAND = 2'b01, OP_XNOR = 2'b10, OP_NOR = 2'b11} op_e;

  state_e   state;
  op_e      op_q;
  logic [IW-1:0] idx;
  logic     vld_q;
  logic     busy_q;
  logic     done_q;
  logic [IW-1:0] last;

  // lane k carries gate input N_IN-1-k, so the packed lane array is rec_in directly
  logic [N_IN-1:0][1:0] dig;
  logic [N_IN-1:0][1:0] sym;
  logic [1:0]           buf_dig;
  logic [N_IN-1:0]      is0, is1, isx;
  logic [1:0]           out_c;

  // row index -> per-input digit (base 4 uses bit pairs, base 2 uses single bits)
  for (genvar k = 0; k < N_IN; k++) begin : g_dig
    if (FOUR_STATE) begin : g4
      assign dig[k] = idx[2*k +: 2];
    end else begin : g2
      assign dig[k] = {1'b0, idx[k]};
    end
  end

  if (FOUR_STATE) begin : g_buf4
    assign buf_dig = idx[1:0];
  end else begin : g_buf2
    // the upper half of the index never leaves zero in two-state mode
    logic unused_hi;
    assign buf_dig   = {1'b0, idx[0]};
    assign unused_hi = ^idx[IW-1:N_IN];
  end

  // BUF sweeps only input 0 (top lane); the other inputs sit at symbol 0
  always_comb begin
    sym = dig;
    if (op_q == OP_BUF) begin
      sym         = '0;
      sym[N_IN-1] = buf_dig;
    end
  end

  gts_lane u_lane [N_IN-1:0] (
    .sym (sym),
    .is0 (is0),
    .is1 (is1),
    .isx (isx)
  );

  // gate evaluation with primitive semantics; output defaults to x and is never z
  always_comb begin
    out_c = 2'b10;
    unique case (op_q)
      OP_BUF:  out_c = isx[N_IN-1] ? 2'b10 : {1'b0, is1[N_IN-1]};
      OP_NAND: begin
        if (|is0)      out_c = 2'b01;
        else if (&is1) out_c = 2'b00;
      end
      OP_XNOR: begin
        if (!(|isx))   out_c = {1'b0, ~^is1};
      end
      OP_NOR: begin
        if (|is1)      out_c = 2'b00;
        else if (&is0) out_c = 2'b01;
      end
    endcase
  end

  assign last = (op_q == OP_BUF) ? LAST_BUF : LAST_ALL;

  // sweep control: latch op on start, advance on each handshake, one DONE cycle at the end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_BUF;
      idx    <= '0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_EMIT;
            op_q   <= op_e'(op);
            idx    <= '0;
            vld_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (rec.rec_ready) begin
            if (idx == last) begin
              state  <= S_DONE;
              vld_q  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rec.rec_valid = vld_q;
  assign rec.rec_idx   = idx;
  assign rec.rec_in    = sym;
  assign rec.rec_out   = out_c;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_gate_table_sweeper.sv
// Bench for gate_table_sweeper: two instances (2-input four-state, 3-input two-state),
// a queue scoreboard fed from a counting reference model, and a negedge monitor.
module tb_gate_table_sweeper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [1:0] op0, op1;
  logic       busy0, busy1, done0, done1;

  gate_table_sweeper_if #(.N_IN(2)) r0 ();
  gate_table_sweeper_if #(.N_IN(3)) r1 ();

  gate_table_sweeper #(.N_IN(2), .FOUR_STATE(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op0),
    .busy(busy0), .done(done0), .rec(r0.master));

  gate_table_sweeper #(.N_IN(3), .FOUR_STATE(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1),
    .busy(busy1), .done(done1), .rec(r1.master));

  typedef struct {
    int idx;
    int in_enc;
    int out;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int checks = 0;
  int errors = 0;
  int dones0 = 0;
  int dones1 = 0;
  bit pv[2], pr[2], pd[2];
  int pidx[2], pin[2], pout[2];

  task automatic chk(input int d, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d, expected %0d", d, name, act, exp);
    end
  endtask

  // reference: symbols as integers 0,1,2(x),3(z); evaluate by counting 0s, 1s and unknowns
  function automatic rec_t ref_row(input int nin, input int fs, input int op, input int r);
    int syms;
    int s[4];
    int n0, n1, nx;
    rec_t t;
    syms = fs ? 4 : 2;
    n0 = 0; n1 = 0; nx = 0;
    t.idx = r;
    t.in_enc = 0;
    for (int i = 0; i < nin; i++) begin
      if (op == 0) s[i] = (i == 0) ? r : 0;
      else         s[i] = (r / (syms ** (nin - 1 - i))) % syms;
      t.in_enc = t.in_enc | (s[i] << (2 * (nin - 1 - i)));
      if (s[i] == 0)      n0++;
      else if (s[i] == 1) n1++;
      else                nx++;
    end
    case (op)
      0:       t.out = (s[0] >= 2) ? 2 : s[0];
      1:       t.out = (n0 > 0) ? 1 : ((n1 == nin) ? 0 : 2);
      2:       t.out = (nx > 0) ? 2 : (((n1 % 2) == 0) ? 1 : 0);
      default: t.out = (n1 > 0) ? 0 : ((n0 == nin) ? 1 : 2);
    endcase
    return t;
  endfunction

  task automatic mon(input int d, input bit v, input bit rdy, input int ix, input int ie,
                     input int ou, input bit bsy, input bit dn);
    rec_t e;
    int qs;
    if (pv[d] && !pr[d]) begin
      chk(d, "hold valid", int'(v), 1);
      chk(d, "hold idx", ix, pidx[d]);
      chk(d, "hold in", ie, pin[d]);
      chk(d, "hold out", ou, pout[d]);
    end
    if (v) chk(d, "busy in emit", int'(bsy), 1);
    if (v && rdy) begin
      qs = d ? q1.size() : q0.size();
      if (qs == 0) chk(d, "spurious record", 1, 0);
      else begin
        if (d != 0) e = q1.pop_front();
        else        e = q0.pop_front();
        chk(d, "rec_idx", ix, e.idx);
        chk(d, "rec_in", ie, e.in_enc);
        chk(d, "rec_out", ou, e.out);
      end
    end
    if (dn) begin
      if (d != 0) dones1++;
      else        dones0++;
      chk(d, "busy in done", int'(bsy), 1);
      chk(d, "valid in done", int'(v), 0);
      chk(d, "rows left at done", d ? q1.size() : q0.size(), 0);
    end
    if (pd[d]) begin
      chk(d, "done width", int'(dn), 0);
      chk(d, "busy after done", int'(bsy), 0);
    end
    pv[d] = v; pr[d] = rdy; pidx[d] = ix; pin[d] = ie; pout[d] = ou; pd[d] = dn;
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, r0.rec_valid, r0.rec_ready, int'(r0.rec_idx), int'(r0.rec_in), int'(r0.rec_out), busy0, done0);
      mon(1, r1.rec_valid, r1.rec_ready, int'(r1.rec_idx), int'(r1.rec_in), int'(r1.rec_out), busy1, done1);
    end else begin
      pv[0] = 0; pv[1] = 0; pd[0] = 0; pd[1] = 0;
    end
  end

  task automatic push_rows(input int d, input int op);
    int nin, fs, cnt;
    nin = d ? 3 : 2;
    fs  = d ? 0 : 1;
    cnt = (op == 0) ? (fs ? 4 : 2) : ((fs ? 4 : 2) ** nin);
    for (int r = 0; r < cnt; r++) begin
      if (d != 0) q1.push_back(ref_row(nin, fs, op, r));
      else        q0.push_back(ref_row(nin, fs, op, r));
    end
  endtask

  // full sweep; called just after a rising edge
  task automatic sweep(input int d, input int op, input bit rnd);
    int cnt, dn0, cyc;
    cnt = d ? ((op == 0) ? 2 : 8) : ((op == 0) ? 4 : 16);
    dn0 = d ? dones1 : dones0;
    cyc = 0;
    push_rows(d, op);
    if (d != 0) begin op1 = 2'(op); start1 = 1'b1; end
    else        begin op0 = 2'(op); start0 = 1'b1; end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    op0 = 2'($urandom); op1 = 2'($urandom);
    while (((d ? dones1 : dones0) == dn0) && cyc < 4000) begin
      if (d != 0) r1.rec_ready = rnd ? 1'($urandom) : 1'b1;
      else        r0.rec_ready = rnd ? 1'($urandom) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk(d, "sweep completes", (cyc < 4000) ? 1 : 0, 1);
    if (!rnd) chk(d, "sweep cycles", cyc, cnt + 1);
    chk(d, "rows left after sweep", d ? q1.size() : q0.size(), 0);
    r0.rec_ready = 1'b1; r1.rec_ready = 1'b1;
  endtask

  task automatic bp_test();
    int cyc, dn0;
    cyc = 0;
    dn0 = dones0;
    push_rows(0, 1);
    op0 = 2'b01; start0 = 1'b1; r0.rec_ready = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    while (r0.rec_idx != 4'd6 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    r0.rec_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk(0, "bp valid", int'(r0.rec_valid), 1);
      chk(0, "bp idx", int'(r0.rec_idx), 6);
      chk(0, "bp in", int'(r0.rec_in), 6);
      chk(0, "bp out", int'(r0.rec_out), 2);
      @(posedge clk); #1;
    end
    r0.rec_ready = 1'b1;
    @(posedge clk); #1;
    chk(0, "bp resume idx", int'(r0.rec_idx), 7);
    cyc = 0;
    while (dones0 == dn0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk(0, "bp sweep completes", (cyc < 100) ? 1 : 0, 1);
  endtask

  task automatic reset_mid();
    int cyc, dn0;
    cyc = 0;
    dn0 = dones0;
    push_rows(0, 1);
    op0 = 2'b01; start0 = 1'b1; r0.rec_ready = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    while (r0.rec_idx != 4'd9 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q0.delete();
    @(negedge clk);
    chk(0, "mid-reset valid", int'(r0.rec_valid), 0);
    chk(0, "mid-reset busy", int'(busy0), 0);
    chk(0, "mid-reset done", int'(done0), 0);
    chk(0, "mid-reset idx", int'(r0.rec_idx), 0);
    chk(0, "mid-reset in", int'(r0.rec_in), 0);
    chk(0, "mid-reset out", int'(r0.rec_out), 0);
    repeat (3) @(posedge clk);
    #1;
    chk(0, "no done after abort", dones0, dn0);
    sweep(0, 2, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start0 = 1'b1; start1 = 1'b1;
    op0 = 2'b01; op1 = 2'b11;
    r0.rec_ready = 1'b1; r1.rec_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(0, "reset valid", int'(r0.rec_valid), 0);
    chk(0, "reset busy", int'(busy0), 0);
    chk(0, "reset done", int'(done0), 0);
    chk(0, "reset idx", int'(r0.rec_idx), 0);
    chk(0, "reset in", int'(r0.rec_in), 0);
    chk(0, "reset out", int'(r0.rec_out), 0);
    chk(1, "reset valid", int'(r1.rec_valid), 0);
    chk(1, "reset busy", int'(busy1), 0);
    start0 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(0, "idle valid after reset", int'(r0.rec_valid), 0);
    chk(1, "idle valid after reset", int'(r1.rec_valid), 0);

    sweep(0, 1, 1'b0);   // NAND, four-state, full rate
    sweep(0, 2, 1'b0);   // XNOR
    sweep(0, 0, 1'b0);   // BUF
    sweep(1, 3, 1'b0);   // NOR, two-state, three inputs
    bp_test();
    reset_mid();
    for (int i = 0; i < 6; i++) begin
      sweep(0, int'($urandom_range(3, 0)), 1'b1);
      sweep(1, int'($urandom_range(3, 0)), 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
